// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit: shift-add multiply and restoring
// divide, one bit per cycle, with valid/ready handshakes on both sides and abort.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state_reg;
    logic [2:0]         op_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               sa_reg;
    logic               sb_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [CW-1:0]      cnt_reg;
    logic [WIDTH-1:0]   dout_reg;

    // Accept-side decode
    logic             is_div, s1, s2, neg1, neg2, div_zero, div_ovf, special, accept;
    logic [WIDTH-1:0] mag1, mag2, special_result;

    always_comb begin
        is_div         = op[2];
        s1             = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        s2             = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        neg1           = s1 & d1[WIDTH-1];
        neg2           = s2 & d2[WIDTH-1];
        mag1           = neg1 ? (~d1 + 1'b1) : d1;
        mag2           = neg2 ? (~d2 + 1'b1) : d2;
        div_zero       = is_div && (d2 == '0);
        div_ovf        = is_div && !op[0] && (d1 == MIN_VAL) && (d2 == ONES);
        special        = div_zero || div_ovf;
        special_result = div_zero ? (op[1] ? d1 : ONES) : (op[1] ? '0 : d1);
        accept         = in_valid && (state_reg == IDLE) && !abort;
    end

    // One iteration of each algorithm; acc holds {hi/remainder, lo/multiplier-or-quotient}
    logic [WIDTH:0]     mul_sum, div_cand, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] mul_next, div_next;

    always_comb begin
        mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, a_reg} : '0);
        mul_next = {mul_sum, acc_reg[WIDTH-1:1]};
        div_cand = acc_reg[2*WIDTH-1:WIDTH-1];
        div_diff = div_cand - {1'b0, b_reg};
        div_ge   = !div_diff[WIDTH];
        div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_cand[WIDTH-1:0]),
                    acc_reg[WIDTH-2:0], div_ge};
    end

    // Sign correction and result selection
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, fix_result;

    always_comb begin
        prod = (sa_reg ^ sb_reg) ? (~acc_reg + 1'b1) : acc_reg;
        quo  = (sa_reg ^ sb_reg) ? (~acc_reg[WIDTH-1:0] + 1'b1) : acc_reg[WIDTH-1:0];
        rem  = sa_reg ? (~acc_reg[2*WIDTH-1:WIDTH] + 1'b1) : acc_reg[2*WIDTH-1:WIDTH];
        case (op_reg)
            3'b000:                 fix_result = prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_result = prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fix_result = quo;
            default:                fix_result = rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            sa_reg    <= 1'b0;
            sb_reg    <= 1'b0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            dout_reg  <= '0;
        end else if (abort) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE: if (accept) begin
                    op_reg  <= op;
                    a_reg   <= mag1;
                    b_reg   <= mag2;
                    sa_reg  <= neg1;
                    sb_reg  <= neg2;
                    acc_reg <= {{WIDTH{1'b0}}, (is_div ? mag1 : mag2)};
                    cnt_reg <= '0;
                    if (special) begin
                        dout_reg  <= special_result;
                        state_reg <= DONE;
                    end else begin
                        state_reg <= CALC;
                    end
                end
                CALC: begin
                    acc_reg <= op_reg[2] ? div_next : mul_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CW'(WIDTH-1))
                        state_reg <= FIX;
                end
                FIX: begin
                    dout_reg  <= fix_result;
                    state_reg <= DONE;
                end
                DONE: if (out_ready) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg == CALC) || (state_reg == FIX);
    assign dout      = dout_reg;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: 32-bit and 8-bit instances, latency, backpressure,
// abort and asynchronous reset.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid32 = 0, abort32 = 0, out_ready32 = 0;
    logic [2:0]  op32 = '0;
    logic [31:0] d1_32 = '0, d2_32 = '0;
    logic        in_ready32, out_valid32, busy32;
    logic [31:0] dout32;
    logic        in_valid8 = 0, abort8 = 0, out_ready8 = 0;
    logic [2:0]  op8 = '0;
    logic [7:0]  d1_8 = '0, d2_8 = '0;
    logic        in_ready8, out_valid8, busy8;
    logic [7:0]  dout8;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32), .op(op32),
        .d1(d1_32), .d2(d2_32), .abort(abort32), .out_valid(out_valid32),
        .out_ready(out_ready32), .dout(dout32), .busy(busy32)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
        .d1(d1_8), .d2(d2_8), .abort(abort8), .out_valid(out_valid8),
        .out_ready(out_ready8), .dout(dout8), .busy(busy8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Issue one op at 1 time unit after an edge; latency counts edges from the accepting edge.
    task automatic run32(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int  lat = 0;
        bit  busy_seen = 0;
        op32 = o; d1_32 = a; d2_32 = b; in_valid32 = 1;
        do begin
            @(posedge clk); #1;
            in_valid32 = 0;
            lat++;
            if (busy32) busy_seen = 1;
        end while (!out_valid32 && lat < 100);
        check({tag, " dout"}, 64'(dout32), 64'(exp));
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        if (exp_lat == 1) check({tag, " busy_seen"}, 64'(busy_seen), 64'd0);
        out_ready32 = 1;
        @(posedge clk); #1;
        out_ready32 = 0;
        check({tag, " in_ready_after"}, 64'(in_ready32), 64'd1);
    endtask

    task automatic run8(input string tag, input logic [2:0] o, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp, input int exp_lat);
        int lat = 0;
        op8 = o; d1_8 = a; d2_8 = b; in_valid8 = 1;
        do begin
            @(posedge clk); #1;
            in_valid8 = 0;
            lat++;
        end while (!out_valid8 && lat < 100);
        check({tag, " dout"}, 64'(dout8), 64'(exp));
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        out_ready8 = 1;
        @(posedge clk); #1;
        out_ready8 = 0;
    endtask

    initial begin
        int lat;
        bit seen;
        logic [31:0] held;

        #1;
        check("reset in_ready", 64'(in_ready32), 64'd1);
        check("reset out_valid", 64'(out_valid32), 64'd0);
        check("reset busy", 64'(busy32), 64'd0);
        check("reset dout", 64'(dout32), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        run32("MULHU", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
        run32("MUL",   3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 34);
        run32("MULH",  3'b001, 32'hFFFFFFF6, 32'h00000003, 32'hFFFFFFFF, 34);
        run32("DIV",   3'b100, 32'hFFFFFFF6, 32'h00000003, 32'hFFFFFFFD, 34);
        run32("REM",   3'b110, 32'hFFFFFFF6, 32'h00000003, 32'hFFFFFFFF, 34);
        run32("DIVU",  3'b101, 32'hFFFFFFF6, 32'h00000002, 32'h7FFFFFFB, 34);
        run32("REMU",  3'b111, 32'hFFFFFFF6, 32'h00000002, 32'h00000000, 34);
        run32("DIVU_by0", 3'b101, 32'h5, 32'h0, 32'hFFFFFFFF, 1);
        run32("REM_by0",  3'b110, 32'h12345678, 32'h0, 32'h12345678, 1);
        run32("DIV_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run32("REM_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

        // Operand change mid-CALC, then output backpressure
        op32 = 3'b101; d1_32 = 32'd100; d2_32 = 32'd7; in_valid32 = 1;
        @(posedge clk); #1;
        in_valid32 = 0;
        repeat (5) @(posedge clk);
        #1 d1_32 = 32'hDEADBEEF; d2_32 = 32'd1; op32 = 3'b000;
        lat = 6;
        while (!out_valid32 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp dout", 64'(dout32), 64'd14);
        held = 32'd14;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("bp hold%0d dout", i), 64'(dout32), 64'(held));
            check($sformatf("bp hold%0d in_ready", i), 64'(in_ready32), 64'd0);
        end
        out_ready32 = 1;
        @(posedge clk); #1;
        out_ready32 = 0;
        check("bp release in_ready", 64'(in_ready32), 64'd1);
        check("bp release out_valid", 64'(out_valid32), 64'd0);

        // Abort during CALC
        op32 = 3'b000; d1_32 = 32'd7; d2_32 = 32'd9; in_valid32 = 1;
        @(posedge clk); #1;
        in_valid32 = 0;
        repeat (10) @(posedge clk);
        #1;
        check("abort busy_before", 64'(busy32), 64'd1);
        abort32 = 1;
        @(posedge clk); #1;
        abort32 = 0;
        check("abort in_ready", 64'(in_ready32), 64'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid32) seen = 1;
        end
        check("abort no out_valid", 64'(seen), 64'd0);

        // Abort together with a request in IDLE
        op32 = 3'b101; d1_32 = 32'd5; d2_32 = 32'd0; in_valid32 = 1; abort32 = 1;
        @(posedge clk); #1;
        in_valid32 = 0; abort32 = 0;
        check("abort_accept in_ready", 64'(in_ready32), 64'd1);
        check("abort_accept out_valid", 64'(out_valid32), 64'd0);
        check("abort_accept busy", 64'(busy32), 64'd0);

        // WIDTH=8 instance
        run8("W8 MULHSU", 3'b010, 8'hFF, 8'hFF, 8'hFF, 10);
        run8("W8 MUL",    3'b000, 8'hFF, 8'hFF, 8'h01, 10);
        run8("W8 DIV_ovf", 3'b100, 8'h80, 8'hFF, 8'h80, 1);

        // Asynchronous reset in the middle of CALC, away from any clock edge
        op32 = 3'b011; d1_32 = 32'h1234; d2_32 = 32'h5678; in_valid32 = 1;
        @(posedge clk); #1;
        in_valid32 = 0;
        repeat (5) @(posedge clk);
        #2;
        check("rst busy_before", 64'(busy32), 64'd1);
        rst = 1'b0;
        #1;
        check("rst in_ready", 64'(in_ready32), 64'd1);
        check("rst busy", 64'(busy32), 64'd0);
        check("rst out_valid", 64'(out_valid32), 64'd0);
        check("rst dout", 64'(dout32), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
